// File: rtl/arp_resolver.sv
// ARP resolution engine: an IP->MAC cache with per-entry ageing, plus a lookup FSM that
// drives the ARP sender on a miss and retries a bounded number of times.
module arp_resolver #(
    parameter int unsigned CACHE_DEPTH = 4,
    parameter int unsigned REQ_TIMEOUT = 125000000,
    parameter int unsigned MAX_RETRIES = 3,
    parameter int unsigned ENTRY_TTL   = 1000000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_lookup_req,
    input  logic [31:0] i_lookup_ip,
    output logic        o_busy,
    output logic        o_lookup_done,
    output logic        o_lookup_hit,
    output logic [47:0] o_lookup_mac,
    input  logic        i_resp_vld,
    input  logic [31:0] i_resp_ip,
    input  logic [47:0] i_resp_mac,
    output logic        o_arp_enable,
    output logic [31:0] o_arp_tpa,
    input  logic        i_arp_ready
);

    localparam int unsigned IW = $clog2(CACHE_DEPTH);
    localparam int unsigned AW = (ENTRY_TTL > 1) ? $clog2(ENTRY_TTL) : 1;
    localparam int unsigned TW = (REQ_TIMEOUT > 1) ? $clog2(REQ_TIMEOUT) : 1;
    localparam int unsigned RW = $clog2(MAX_RETRIES + 1);

    typedef enum logic [2:0] {
        StIdle, StSearch, StStartReq, StSend, StWait, StDone
    } state_e;

    // Cache storage
    logic [CACHE_DEPTH-1:0] valid_q, valid_d;
    logic [31:0]            ip_q  [CACHE_DEPTH];
    logic [31:0]            ip_d  [CACHE_DEPTH];
    logic [47:0]            mac_q [CACHE_DEPTH];
    logic [47:0]            mac_d [CACHE_DEPTH];
    logic [AW-1:0]          age_q [CACHE_DEPTH];
    logic [AW-1:0]          age_d [CACHE_DEPTH];
    logic [IW-1:0]          rr_q, rr_d;

    // FSM state and registered outputs
    state_e        state_q, state_d;
    logic [31:0]   lookup_ip_q, lookup_ip_d;
    logic [RW-1:0] retry_q, retry_d;
    logic [RW-1:0] retry_inc;
    logic [TW-1:0] timer_q, timer_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          hit_q, hit_d;
    logic [47:0]   res_mac_q, res_mac_d;
    logic          enable_q, enable_d;
    logic [31:0]   tpa_q, tpa_d;

    // Parallel compare results
    logic          learn;
    logic          lk_hit;
    logic [47:0]   lk_mac;
    logic          rs_hit;
    logic [IW-1:0] rs_idx;
    logic          free_hit;
    logic [IW-1:0] free_idx;
    logic [IW-1:0] wr_idx;

    assign learn = i_resp_vld && (i_resp_ip != 32'd0);

    always_comb begin
        lk_hit   = 1'b0;
        lk_mac   = '0;
        rs_hit   = 1'b0;
        rs_idx   = '0;
        free_hit = 1'b0;
        free_idx = '0;
        for (int unsigned i = 0; i < CACHE_DEPTH; i++) begin
            if (valid_q[i] && ip_q[i] == lookup_ip_q && !lk_hit) begin
                lk_hit = 1'b1;
                lk_mac = mac_q[i];
            end
            if (valid_q[i] && ip_q[i] == i_resp_ip && !rs_hit) begin
                rs_hit = 1'b1;
                rs_idx = IW'(i);
            end
            if (!valid_q[i] && !free_hit) begin
                free_hit = 1'b1;
                free_idx = IW'(i);
            end
        end
    end

    // Ageing first, then the learn write so a refresh on the expiry cycle keeps the entry.
    always_comb begin
        valid_d = valid_q;
        ip_d    = ip_q;
        mac_d   = mac_q;
        age_d   = age_q;
        rr_d    = rr_q;
        wr_idx  = rr_q;
        for (int unsigned i = 0; i < CACHE_DEPTH; i++) begin
            if (valid_q[i]) begin
                if (age_q[i] == AW'(ENTRY_TTL - 1)) begin
                    valid_d[i] = 1'b0;
                    age_d[i]   = '0;
                end else begin
                    age_d[i] = age_q[i] + AW'(1);
                end
            end
        end
        if (learn) begin
            if (rs_hit) begin
                wr_idx = rs_idx;
            end else if (free_hit) begin
                wr_idx = free_idx;
            end else begin
                wr_idx = rr_q;
                rr_d   = (rr_q == IW'(CACHE_DEPTH - 1)) ? '0 : rr_q + IW'(1);
            end
            valid_d[wr_idx] = 1'b1;
            ip_d[wr_idx]    = i_resp_ip;
            mac_d[wr_idx]   = i_resp_mac;
            age_d[wr_idx]   = '0;
        end
    end

    always_comb begin
        state_d     = state_q;
        lookup_ip_d = lookup_ip_q;
        retry_d     = retry_q;
        retry_inc   = retry_q + RW'(1);
        timer_d     = timer_q;
        hit_d       = hit_q;
        res_mac_d   = res_mac_q;
        tpa_d       = tpa_q;
        unique case (state_q)
            StIdle: begin
                if (i_lookup_req) begin
                    lookup_ip_d = i_lookup_ip;
                    state_d     = StSearch;
                end
            end
            StSearch: begin
                if (lk_hit) begin
                    hit_d     = 1'b1;
                    res_mac_d = lk_mac;
                    state_d   = StDone;
                end else begin
                    retry_d = '0;
                    tpa_d   = lookup_ip_q;
                    state_d = StStartReq;
                end
            end
            StStartReq: begin
                if (!i_arp_ready) state_d = StSend;
            end
            StSend: begin
                if (i_arp_ready) begin
                    timer_d = '0;
                    state_d = StWait;
                end
            end
            StWait: begin
                timer_d = timer_q + TW'(1);
                if (learn && i_resp_ip == lookup_ip_q) begin
                    hit_d     = 1'b1;
                    res_mac_d = i_resp_mac;
                    state_d   = StDone;
                end else if (lk_hit) begin
                    // Reply already learned while the request was still being sent
                    hit_d     = 1'b1;
                    res_mac_d = lk_mac;
                    state_d   = StDone;
                end else if (timer_q == TW'(REQ_TIMEOUT - 1)) begin
                    retry_d = retry_inc;
                    if (32'(retry_inc) < MAX_RETRIES) begin
                        state_d = StStartReq;
                    end else begin
                        hit_d     = 1'b0;
                        res_mac_d = '0;
                        state_d   = StDone;
                    end
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
        busy_d   = (state_d != StIdle);
        done_d   = (state_d == StDone);
        enable_d = (state_d == StStartReq);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            rr_q    <= '0;
            for (int unsigned i = 0; i < CACHE_DEPTH; i++) begin
                ip_q[i]  <= '0;
                mac_q[i] <= '0;
                age_q[i] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            rr_q    <= rr_d;
            ip_q    <= ip_d;
            mac_q   <= mac_d;
            age_q   <= age_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            lookup_ip_q <= '0;
            retry_q     <= '0;
            timer_q     <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            hit_q       <= 1'b0;
            res_mac_q   <= '0;
            enable_q    <= 1'b0;
            tpa_q       <= '0;
        end else begin
            state_q     <= state_d;
            lookup_ip_q <= lookup_ip_d;
            retry_q     <= retry_d;
            timer_q     <= timer_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            hit_q       <= hit_d;
            res_mac_q   <= res_mac_d;
            enable_q    <= enable_d;
            tpa_q       <= tpa_d;
        end
    end

    assign o_busy        = busy_q;
    assign o_lookup_done = done_q;
    assign o_lookup_hit  = hit_q;
    assign o_lookup_mac  = res_mac_q;
    assign o_arp_enable  = enable_q;
    assign o_arp_tpa     = tpa_q;

endmodule
